// File: rtl/game_pixel_scaler_if.sv
// Video timing in (hen/ven) and scaled logical coordinates out.
// The timing generator side is the master; the scaler is the slave.
interface game_pixel_scaler_if #(
    parameter int XW = 8,
    parameter int YW = 9
);
    logic          hen;
    logic          ven;
    logic [XW-1:0] pixel_x;
    logic [YW-1:0] pixel_y;
    logic [3:0]    sub_x;
    logic [3:0]    sub_y;
    logic          in_display;
    logic          line_start;
    logic          frame_start;
    logic [7:0]    frame_cnt;

    modport master (
        output hen, ven,
        input  pixel_x, pixel_y, sub_x, sub_y,
        input  in_display, line_start, frame_start, frame_cnt
    );

    modport slave (
        input  hen, ven,
        output pixel_x, pixel_y, sub_x, sub_y,
        output in_display, line_start, frame_start, frame_cnt
    );
endinterface

// File: rtl/game_pixel_scaler.sv
// Maps physical hen/ven timing onto a low-resolution logical frame by
// integer replication. Every output is registered, one pclk behind the
// active pixel it describes. Pixels beyond the logical frame are clipped:
// the counters saturate and the coordinate outputs keep their last
// in-frame value instead of wrapping.
module game_pixel_scaler #(
    parameter int SRC_W   = 200,
    parameter int SRC_H   = 150,
    parameter int SCALE_X = 4,
    parameter int SCALE_Y = 4,
    parameter int XW      = 8,
    parameter int YW      = 9
) (
    input  logic                 pclk,
    input  logic                 rstn,
    game_pixel_scaler_if.slave   vid
);
    // Counter widths must be able to hold the saturation value SRC_W/SRC_H.
    localparam int CXW = $clog2(SRC_W + 1);
    localparam int CYW = $clog2(SRC_H + 1);

    localparam logic [CXW-1:0] CX_MAX  = CXW'(SRC_W);
    localparam logic [CYW-1:0] CY_MAX  = CYW'(SRC_H);
    localparam logic [3:0]     SX_LAST = 4'(SCALE_X - 1);
    localparam logic [3:0]     SY_LAST = 4'(SCALE_Y - 1);

    logic           hen_d, ven_d;
    logic           hen_fall, ven_fall, active, in_frame;
    logic [CXW-1:0] cx;
    logic [CYW-1:0] cy;
    logic [3:0]     sx, sy;
    logic [7:0]     frame_cnt_q;
    logic [XW-1:0]  pixel_x_q;
    logic [YW-1:0]  pixel_y_q;
    logic [3:0]     sub_x_q, sub_y_q;
    logic           in_display_q, line_start_q, frame_start_q;

    assign hen_fall = hen_d & ~vid.hen;
    assign ven_fall = ven_d & ~vid.ven;
    assign active   = vid.hen & vid.ven;
    assign in_frame = (cx < CX_MAX) && (cy < CY_MAX);

    // Edge-detect registers and the logical/phase counters; ven_fall wins over hen_fall.
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            hen_d       <= 1'b0;
            ven_d       <= 1'b0;
            cx          <= '0;
            sx          <= '0;
            cy          <= '0;
            sy          <= '0;
            frame_cnt_q <= '0;
        end else begin
            hen_d <= vid.hen;
            ven_d <= vid.ven;
            if (ven_fall) begin
                cx          <= '0;
                sx          <= '0;
                cy          <= '0;
                sy          <= '0;
                frame_cnt_q <= frame_cnt_q + 8'd1;
            end else if (hen_fall) begin
                cx <= '0;
                sx <= '0;
                if (cy != CY_MAX) begin
                    if (sy == SY_LAST) begin
                        sy <= '0;
                        cy <= cy + 1'b1;
                    end else begin
                        sy <= sy + 4'd1;
                    end
                end
            end else if (active && (cx != CX_MAX)) begin
                if (sx == SX_LAST) begin
                    sx <= '0;
                    cx <= cx + 1'b1;
                end else begin
                    sx <= sx + 4'd1;
                end
            end
        end
    end

    // Registered coordinate outputs and start pulses; coordinates only move inside the frame.
    always_ff @(posedge pclk) begin
        if (!rstn) begin
            pixel_x_q     <= '0;
            pixel_y_q     <= '0;
            sub_x_q       <= '0;
            sub_y_q       <= '0;
            in_display_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
        end else begin
            in_display_q  <= 1'b0;
            line_start_q  <= 1'b0;
            frame_start_q <= 1'b0;
            if (active && in_frame) begin
                pixel_x_q     <= XW'(cx);
                pixel_y_q     <= YW'(cy);
                sub_x_q       <= sx;
                sub_y_q       <= sy;
                in_display_q  <= 1'b1;
                line_start_q  <= (cx == '0) && (sx == '0);
                frame_start_q <= (cx == '0) && (sx == '0) && (cy == '0) && (sy == '0);
            end
        end
    end

    assign vid.pixel_x     = pixel_x_q;
    assign vid.pixel_y     = pixel_y_q;
    assign vid.sub_x       = sub_x_q;
    assign vid.sub_y       = sub_y_q;
    assign vid.in_display  = in_display_q;
    assign vid.line_start  = line_start_q;
    assign vid.frame_start = frame_start_q;
    assign vid.frame_cnt   = frame_cnt_q;
endmodule
